aes_ahb_master: RTL and testbench
=================================

AES_AHB_MASTER -- requirements
Module: aes_ahb_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000, base of the AES peripheral register map.
REQ-002 Parameter POLL_LIMIT, default 1024, maximum DONE_STATUS reads before timeout (16-bit counter).
REQ-003 HCLK  in  1  sole clock; all logic rising-edge.
REQ-004 HRESETn  in  1  asynchronous, active-low reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  request handshake; transfer when both high at an HCLK edge.
REQ-006 key_i, plaintext_i  in  128 each  key and plaintext, sampled on the request transfer.
REQ-007 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-008 ciphertext_o  out  128  result; err_o  out  1  result is an error; busy_o  out  1  sequence in progress.
REQ-009 AHB-Lite master outputs: HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK, HWDATA[31:0].
REQ-010 AHB-Lite master inputs: HREADY, HRESP, HRDATA[31:0].

Function
REQ-011 Fixed outputs: HSIZE=3'b010, HBURST=3'b000, HPROT=4'b0011, HMASTLOCK=0; only IDLE (00) and NONSEQ (10) are issued.
REQ-012 Each transfer: one address-phase cycle (HTRANS=NONSEQ), then data phase (HTRANS=IDLE) until HREADY=1 is sampled; no pipelining; the next transfer's address phase starts the cycle after completion.
REQ-013 On writes, HWDATA is driven with the write value in both the address-phase and data-phase cycles; HADDR/HWRITE are held through the data phase.
REQ-014 States: IDLE, ADDR, DATA, RESULT; a 4-bit step counter selects the operation.
REQ-015 in_ready=1 only in IDLE; busy_o=1 in ADDR and DATA.
REQ-016 Step order: write BASE+0x00..0x0C = key_i[31:0], [63:32], [95:64], [127:96]; write BASE+0x10..0x1C = plaintext_i words in the same order; write BASE+0x20 = 1; write BASE+0x20 = 0; poll-read BASE+0x34; read BASE+0x24..0x30 into ciphertext_o[31:0]..[127:96].
REQ-017 Poll: HRDATA[0]=1 at data-phase completion advances to the cipher reads; 0 reissues the poll immediately.
REQ-018 Timeout: after POLL_LIMIT polls all returning 0, go to RESULT with err_o=1, ciphertext_o=0.
REQ-019 HRESP=1 sampled at any data-phase edge aborts: no further transfers, RESULT with err_o=1, ciphertext_o=0.
REQ-020 Read data is captured only at data-phase edges with HREADY=1.
REQ-021 Request accepted at edge T: first NONSEQ occupies cycle T..T+1; with HREADY=1 throughout and done on the first poll, out_valid rises 31 cycles after T (15 transfers x 2 + 1).
REQ-022 RESULT: out_valid=1, ciphertext_o/err_o stable until out_ready=1 sampled, then return to IDLE; in_ready is asserted the cycle after out_valid deasserts.
REQ-023 in_valid while busy is ignored; inputs are captured only at acceptance, so later input changes have no effect.

Reset
REQ-024 HRESETn low (any state, including mid-transfer) asynchronously forces: IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, out_valid=0, err_o=0, ciphertext_o=0, busy_o=0, step and poll counters 0; in_ready=1 after release.

Verification
REQ-025 Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, slave model with real core -> ciphertext_o=69c4e0d86a7b0430d8cdb78070b4c55a, err_o=0.
REQ-026 HREADY=1, done on first poll -> exact address sequence 0x00,04,...,0x20,0x20,0x34,0x24,0x28,0x2C,0x30 (offsets from BASE) and out_valid 31 cycles after acceptance.
REQ-027 Slave inserts 3 wait states on every transfer -> HADDR/HWDATA held stable, same result, latency 31+45=76 cycles.
REQ-028 DONE held 0, POLL_LIMIT=4 -> exactly 4 reads of 0x34, then out_valid=1, err_o=1, ciphertext_o=0.
REQ-029 HRESP=1 on the 3rd write -> no 4th transfer, out_valid=1 with err_o=1; out_ready held low 10 cycles -> outputs stable, then IDLE.
REQ-030 HRESETn asserted during the 6th transfer's data phase -> all outputs at reset values immediately; new request after release runs a full, correct sequence.

Source files
------------

// File: rtl/aes_ahb_master_if.sv
// rtl/aes_ahb_master_if.sv - request/result handshakes and AHB-Lite master bus for aes_ahb_master
interface aes_ahb_master_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_i;
    logic [127:0] plaintext_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext_o;
    logic         err_o;
    logic         busy_o;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    logic         HMASTLOCK;
    logic [31:0]  HWDATA;
    logic         HREADY;
    logic         HRESP;
    logic [31:0]  HRDATA;

    modport master (
        input  in_valid, key_i, plaintext_i, out_ready, HREADY, HRESP, HRDATA,
        output in_ready, out_valid, ciphertext_o, err_o, busy_o,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        output in_valid, key_i, plaintext_i, out_ready, HREADY, HRESP, HRDATA,
        input  in_ready, out_valid, ciphertext_o, err_o, busy_o,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/aes_ahb_master.sv
// rtl/aes_ahb_master.sv - AHB-Lite master sequencing one AES-128 encryption on a memory-mapped core
module aes_ahb_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter logic [15:0] POLL_LIMIT = 16'd1024
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    aes_ahb_master_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESULT} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [3:0] STEP_POLL     = 4'd10;
    localparam logic [3:0] STEP_READ0    = 4'd11;
    localparam logic [3:0] STEP_LAST     = 4'd14;

    state_t       r_state;
    logic [3:0]   r_step;
    logic [15:0]  r_poll_cnt;
    logic [127:0] r_key;
    logic [127:0] r_pt;
    logic [127:0] r_ct;
    logic         r_out_valid;
    logic         r_err;
    logic [31:0]  r_haddr;
    logic [31:0]  r_hwdata;
    logic [1:0]   r_htrans;
    logic         r_hwrite;

    logic [3:0]   w_issue_step;
    logic [127:0] w_src_key;
    logic [127:0] w_src_pt;
    logic         w_issue_write;
    logic [31:0]  w_issue_addr;
    logic [31:0]  w_issue_wdata;
    logic         w_poll_miss;
    logic         w_poll_timeout;
    logic [1:0]   w_rd_word;

    // Steps 0-7 key/plaintext words, 8/9 start pulse, 10 poll, 11-14 cipher words.
    function automatic logic [31:0] step_offset(input logic [3:0] s);
        if (s <= 4'd8)
            return {26'd0, s, 2'b00};
        else if (s == 4'd9)
            return 32'h0000_0020;
        else if (s == STEP_POLL)
            return 32'h0000_0034;
        else
            return {26'd0, s - 4'd2, 2'b00};
    endfunction

    function automatic logic step_is_write(input logic [3:0] s);
        return s <= 4'd9;
    endfunction

    function automatic logic [31:0] step_wdata(input logic [3:0] s, input logic [127:0] key,
                                               input logic [127:0] pt);
        if (s <= 4'd3)
            return key[{s[1:0], 5'd0} +: 32];
        else if (s <= 4'd7)
            return pt[{s[1:0], 5'd0} +: 32];
        else if (s == 4'd8)
            return 32'd1;
        else
            return 32'd0;
    endfunction

    always_comb begin
        w_poll_miss    = (r_step == STEP_POLL) && !bus.HRDATA[0];
        w_poll_timeout = (r_poll_cnt + 16'd1) == POLL_LIMIT;
        w_rd_word      = r_step[1:0] + 2'd1;
        w_src_key      = (r_state == ST_IDLE) ? bus.key_i : r_key;
        w_src_pt       = (r_state == ST_IDLE) ? bus.plaintext_i : r_pt;
        if (r_state == ST_IDLE)
            w_issue_step = 4'd0;
        else if (w_poll_miss)
            w_issue_step = STEP_POLL;
        else
            w_issue_step = r_step + 4'd1;
        w_issue_write = step_is_write(w_issue_step);
        w_issue_addr  = BASE_ADDR + step_offset(w_issue_step);
        w_issue_wdata = w_issue_write ? step_wdata(w_issue_step, w_src_key, w_src_pt) : 32'd0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_step      <= 4'd0;
            r_poll_cnt  <= 16'd0;
            r_key       <= '0;
            r_pt        <= '0;
            r_ct        <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_haddr     <= 32'd0;
            r_hwdata    <= 32'd0;
            r_htrans    <= HTRANS_IDLE;
            r_hwrite    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_key      <= bus.key_i;
                        r_pt       <= bus.plaintext_i;
                        r_poll_cnt <= 16'd0;
                        r_ct       <= '0;
                        r_err      <= 1'b0;
                        r_step     <= w_issue_step;
                        r_htrans   <= HTRANS_NONSEQ;
                        r_haddr    <= w_issue_addr;
                        r_hwrite   <= w_issue_write;
                        r_hwdata   <= w_issue_wdata;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_htrans <= HTRANS_IDLE;
                    r_state  <= ST_DATA;
                end
                ST_DATA: begin
                    // Error response or poll exhaustion ends the sequence with no result data.
                    if (bus.HRESP || (bus.HREADY && w_poll_miss && w_poll_timeout)) begin
                        r_err    <= 1'b1;
                        r_ct     <= '0;
                        r_haddr  <= 32'd0;
                        r_hwrite <= 1'b0;
                        r_hwdata <= 32'd0;
                        r_state  <= ST_RESULT;
                    end else if (bus.HREADY) begin
                        if (r_step >= STEP_READ0)
                            r_ct[{w_rd_word, 5'd0} +: 32] <= bus.HRDATA;
                        if (w_poll_miss)
                            r_poll_cnt <= r_poll_cnt + 16'd1;
                        if (r_step == STEP_LAST) begin
                            r_haddr  <= 32'd0;
                            r_hwrite <= 1'b0;
                            r_hwdata <= 32'd0;
                            r_state  <= ST_RESULT;
                        end else begin
                            r_step   <= w_issue_step;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= w_issue_addr;
                            r_hwrite <= w_issue_write;
                            r_hwdata <= w_issue_wdata;
                            r_state  <= ST_ADDR;
                        end
                    end
                end
                ST_RESULT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (r_state == ST_IDLE);
    assign bus.busy_o       = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign bus.out_valid    = r_out_valid;
    assign bus.err_o        = r_err;
    assign bus.ciphertext_o = r_ct;
    assign bus.HADDR        = r_haddr;
    assign bus.HTRANS       = r_htrans;
    assign bus.HWRITE       = r_hwrite;
    assign bus.HWDATA       = r_hwdata;
    assign bus.HSIZE        = 3'b010;
    assign bus.HBURST       = 3'b000;
    assign bus.HPROT        = 4'b0011;
    assign bus.HMASTLOCK    = 1'b0;
endmodule

// File: tb/tb_aes_ahb_master.sv
// tb/tb_aes_ahb_master.sv - scoreboard bench with AHB slave wrapping a behavioural AES-128 core
module tb_aes_ahb_master;
    localparam int          PL   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    aes_ahb_master_if bus();

    aes_ahb_master #(.BASE_ADDR(BASE), .POLL_LIMIT(16'd4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
    );

    initial forever #5 HCLK = ~HCLK;

    int checks = 0, failures = 0, cyc = 0;
    typedef struct { logic [127:0] ct; logic err; int lat; } exp_t;
    exp_t        exp_q[$];
    logic [63:0] xfer_log[$];
    logic [63:0] exp_xfers[$];
    logic [7:0]  sbox[256];

    int cfg_waits = 0, cfg_zero = 0, cfg_err_at = 0, xfer_n = 0, poll_n = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v};
        return t[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 AES-128; byte 0 of the block is the most significant byte of the 128-bit value.
    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w[44];
        logic [7:0]  s[16], t[16];
        logic [7:0]  rc = 8'h01, a0, a1, a2, a3;
        logic [31:0] tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
                if (rnd < 10)
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                        s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                    end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] ^= w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // AHB slave: register file + AES core; decisions made at negedge for the following rising edge.
    logic [31:0]  sregs[16];
    logic [127:0] s_cipher = '0;
    logic         dp_valid = 1'b0, dp_write = 1'b0;
    logic [31:0]  dp_addr = '0, dp_wdata = '0, off, rd;
    int           dp_wait = 0, dp_idx = 0;

    initial begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        for (int i = 0; i < 16; i++) sregs[i] = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dp_valid = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
                continue;
            end
            bus.HRESP = 1'b0;
            if (dp_valid) begin
                chk(bus.HADDR == dp_addr && (!dp_write || bus.HWDATA == dp_wdata), "addr_data_hold",
                    {bus.HADDR, bus.HWDATA}, {dp_addr, dp_wdata});
                off = dp_addr - BASE;
                if (dp_idx == cfg_err_at) begin
                    bus.HREADY = 1'b0; bus.HRESP = 1'b1; dp_valid = 1'b0;
                end else if (dp_wait > 0) begin
                    bus.HREADY = 1'b0; bus.HRDATA = $urandom; dp_wait--;
                end else begin
                    bus.HREADY = 1'b1;
                    dp_valid = 1'b0;
                    if (dp_write) begin
                        sregs[off[5:2]] = bus.HWDATA;
                        if (off == 32'h20 && bus.HWDATA[0]) begin
                            s_cipher = aes128({sregs[3], sregs[2], sregs[1], sregs[0]},
                                              {sregs[7], sregs[6], sregs[5], sregs[4]});
                            poll_n = 0;
                        end
                    end else if (off == 32'h34) begin
                        rd = $urandom;
                        rd[0] = (poll_n >= cfg_zero);
                        poll_n++;
                        bus.HRDATA = rd;
                    end else if (off >= 32'h24 && off <= 32'h30) begin
                        bus.HRDATA = s_cipher[(off[5:2] - 4'd9) * 32 +: 32];
                    end else begin
                        bus.HRDATA = sregs[off[5:2]];
                    end
                end
            end else begin
                bus.HREADY = 1'b1;
            end
            if (bus.HTRANS == 2'b10) begin
                dp_valid = 1'b1; dp_addr = bus.HADDR; dp_write = bus.HWRITE;
                dp_wdata = bus.HWDATA; dp_wait = cfg_waits;
                xfer_n++; dp_idx = xfer_n;
                xfer_log.push_back({bus.HADDR - BASE, bus.HWRITE ? bus.HWDATA : 32'd0});
            end
        end
    end

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    // Monitor: pops one expectation per result and compares outputs, latency and bus trace.
    int   t_acc = 0;
    bit   seen = 0, hs = 0;
    exp_t cur;
    initial forever begin
        @(negedge HCLK);
        if (!HRESETn) begin
            seen = 0; hs = 0;
            continue;
        end
        if (bus.in_valid && bus.in_ready) t_acc = cyc + 1;
        if (bus.HTRANS == 2'b10) begin
            chk(bus.busy_o && !bus.in_ready, "busy_during_xfer", {bus.busy_o, bus.in_ready}, 2'b10);
            chk(bus.HSIZE == 3'b010 && bus.HBURST == 3'b000 && bus.HPROT == 4'b0011 && !bus.HMASTLOCK,
                "fixed_ctrl", {bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}, 14'b010_000_0011_0);
        end
        if (bus.out_valid) begin
            if (!seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_result", 1, 0);
                    cur.ct = bus.ciphertext_o; cur.err = bus.err_o;
                end else begin
                    cur = exp_q.pop_front();
                    chk(cyc - t_acc == cur.lat, "latency", cyc - t_acc, cur.lat);
                    chk(xfer_log.size() == exp_xfers.size(), "xfer_count", xfer_log.size(), exp_xfers.size());
                    for (int i = 0; i < xfer_log.size() && i < exp_xfers.size(); i++)
                        chk(xfer_log[i] == exp_xfers[i], "xfer_addr_data", xfer_log[i], exp_xfers[i]);
                end
                xfer_log.delete();
                exp_xfers.delete();
            end
            chk(bus.ciphertext_o == cur.ct, "ciphertext", bus.ciphertext_o, cur.ct);
            chk(bus.err_o == cur.err, "err", bus.err_o, cur.err);
            chk(!bus.busy_o && !bus.in_ready, "result_not_busy", {bus.busy_o, bus.in_ready}, 0);
            if (bus.out_ready) begin hs = 1; seen = 0; end
        end else if (hs) begin
            hs = 0;
            chk(bus.in_ready, "in_ready_after_result", bus.in_ready, 1);
        end
    end

    task automatic wait_in_ready();
        int n = 0;
        while (!bus.in_ready && n < 200) begin @(posedge HCLK); #1; n++; end
        if (!bus.in_ready) chk(0, "in_ready_timeout", 0, 1);
    endtask

    task automatic run_txn(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ref_ct,
                           input int w, input int z, input int e, input int hold);
        logic [63:0] lst[$];
        exp_t x;
        bit   tmo = (z >= PL);
        int   np = tmo ? PL : z + 1;
        int   n = 0;
        for (int i = 0; i < 4; i++) lst.push_back({32'(4*i), key[32*i +: 32]});
        for (int i = 0; i < 4; i++) lst.push_back({32'(16+4*i), pt[32*i +: 32]});
        lst.push_back({32'h20, 32'd1});
        lst.push_back({32'h20, 32'd0});
        for (int i = 0; i < np; i++) lst.push_back({32'h34, 32'd0});
        if (!tmo) for (int i = 0; i < 4; i++) lst.push_back({32'(36+4*i), 32'd0});
        if (e > 0) while (lst.size() > e) void'(lst.pop_back());
        x.err = tmo || (e > 0);
        x.ct  = x.err ? 128'd0 : ref_ct;
        x.lat = (e > 0) ? (e - 1) * (2 + w) + 3 : lst.size() * (2 + w) + 1;
        wait_in_ready();
        exp_xfers = lst;
        exp_q.push_back(x);
        cfg_waits = w; cfg_zero = z; cfg_err_at = e; xfer_n = 0;
        bus.in_valid = 1'b1; bus.key_i = key; bus.plaintext_i = pt;
        @(posedge HCLK); #1;
        bus.key_i = {$urandom, $urandom, $urandom, $urandom};
        bus.plaintext_i = {$urandom, $urandom, $urandom, $urandom};
        if (e == 0) begin
            repeat (4) begin @(posedge HCLK); #1; end
        end
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 3000) begin @(posedge HCLK); #1; n++; end
        if (!bus.out_valid) chk(0, "out_valid_timeout", 0, 1);
        repeat (hold) begin @(posedge HCLK); #1; end
        bus.out_ready = 1'b1;
        @(posedge HCLK); #1;
        bus.out_ready = 1'b0;
        @(posedge HCLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=hang expected=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] KV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PV = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CV = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] rk, rp;
        int n, w, z, e, r;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.key_i = '0; bus.plaintext_i = '0;
        build_sbox();
        repeat (3) @(posedge HCLK);
        #1;
        chk(bus.HTRANS == 2'b00 && bus.HADDR == 0 && !bus.out_valid && !bus.busy_o && bus.ciphertext_o == 0,
            "reset_state", {bus.HTRANS, bus.HADDR, bus.out_valid, bus.busy_o}, 0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk(bus.in_ready, "in_ready_after_reset", bus.in_ready, 1);

        run_txn(KV, PV, CV, 0, 0, 0, 0);
        run_txn(KV, PV, CV, 3, 0, 0, 2);
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        run_txn(rk, rp, aes128(rk, rp), 0, 99, 0, 1);
        run_txn(rk, rp, aes128(rk, rp), 0, 0, 3, 10);

        // Reset during the data phase of the 6th transfer.
        wait_in_ready();
        cfg_waits = 3; cfg_zero = 0; cfg_err_at = 0; xfer_n = 0;
        bus.in_valid = 1'b1; bus.key_i = rk; bus.plaintext_i = rp;
        @(posedge HCLK); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (xfer_n < 6 && n < 500) begin @(posedge HCLK); #1; n++; end
        chk(xfer_n == 6, "reached_6th_xfer", xfer_n, 6);
        #2 HRESETn = 1'b0;
        #1;
        chk(bus.HTRANS == 2'b00, "rst_htrans", bus.HTRANS, 0);
        chk(bus.HADDR == 0, "rst_haddr", bus.HADDR, 0);
        chk(!bus.HWRITE && bus.HWDATA == 0, "rst_hwrite_hwdata", {bus.HWRITE, bus.HWDATA}, 0);
        chk(!bus.out_valid && !bus.err_o && !bus.busy_o, "rst_flags", {bus.out_valid, bus.err_o, bus.busy_o}, 0);
        chk(bus.ciphertext_o == 0, "rst_ciphertext", bus.ciphertext_o, 0);
        repeat (2) begin @(posedge HCLK); #1; end
        HRESETn = 1'b1;
        xfer_log.delete();
        exp_xfers.delete();
        @(posedge HCLK); #1;
        chk(bus.in_ready, "in_ready_after_midreset", bus.in_ready, 1);
        run_txn(KV, PV, CV, 1, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            w = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            e = 0;
            if (r < 6) z = $urandom_range(0, 2);
            else if (r < 8) z = 99;
            else begin z = 0; e = $urandom_range(1, 15); end
            run_txn(rk, rp, aes128(rk, rp), w, z, e, $urandom_range(0, 4));
        end

        repeat (5) @(posedge HCLK);
        if (exp_q.size() != 0) chk(0, "pending_results", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
